// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter_pkg
// Description : Shared types and helpers for the dual-lane data-memory port
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_port_arbiter_pkg;

    localparam int c_addr_w = 32;
    localparam int c_data_w = 32;

    typedef struct packed {
        logic                req;
        logic                we;
        logic [c_addr_w-1:0] addr;
        logic [c_data_w-1:0] wdata;
    } mem_req_per_t;

    typedef struct packed {
        mem_req_per_t a;
        mem_req_per_t b;
    } mem_req_t;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_ISSUE_B = 1'b1
    } arb_state_t;

    function automatic logic is_load(input mem_req_per_t r);
        return r.req && !r.we;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter_if
// Description : Lane request, memory port and load response bundle of the
//               MEM-stage data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              pair_valid;
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    // Pipeline and memory side.
    modport master (
        output pair_valid, a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata, mem_rdata,
        input  stall, mem_en, mem_we, mem_addr, mem_wdata,
        input  a_rvalid, a_rdata, b_rvalid, b_rdata
    );

    // Arbiter side.
    modport slave (
        input  pair_valid, a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata, mem_rdata,
        output stall, mem_en, mem_we, mem_addr, mem_wdata,
        output a_rvalid, a_rdata, b_rvalid, b_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; cleared by reset only.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_inc,
    output logic [W-1:0]      o_count
);
    localparam logic [W-1:0] c_one = W'(1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares one data-memory port between dual-issue lanes A and B,
//               serialising dual-access pairs and steering load responses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w,
    parameter int CNT_W  = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dmem_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0]   conflict_cnt
);
    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              r_b_we;
    logic [ADDR_W-1:0] r_b_addr;
    logic [DATA_W-1:0] r_b_wdata;
    logic              r_tag_a;
    logic              r_tag_b;

    mem_req_t          w_lanes;
    logic              w_en;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_stall;
    logic              w_issue_a_load;
    logic              w_issue_b_load;
    logic              w_latch_b;

    always_comb begin
        w_lanes.a.req   = bus.a_req;
        w_lanes.a.we    = bus.a_we;
        w_lanes.a.addr  = bus.a_addr;
        w_lanes.a.wdata = bus.a_wdata;
        w_lanes.b.req   = bus.b_req;
        w_lanes.b.we    = bus.b_we;
        w_lanes.b.addr  = bus.b_addr;
        w_lanes.b.wdata = bus.b_wdata;
    end

    always_comb begin
        w_next         = r_state;
        w_en           = 1'b0;
        w_we           = 1'b0;
        w_addr         = '0;
        w_wdata        = '0;
        w_stall        = 1'b0;
        w_issue_a_load = 1'b0;
        w_issue_b_load = 1'b0;
        w_latch_b      = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (bus.pair_valid) begin
                    if (w_lanes.a.req) begin
                        w_en           = 1'b1;
                        w_we           = w_lanes.a.we;
                        w_addr         = w_lanes.a.addr;
                        w_wdata        = w_lanes.a.wdata;
                        w_issue_a_load = is_load(w_lanes.a);
                        // Both lanes want the port: A now, B next cycle.
                        if (w_lanes.b.req) begin
                            w_stall   = 1'b1;
                            w_latch_b = 1'b1;
                            w_next    = ARB_ISSUE_B;
                        end
                    end else if (w_lanes.b.req) begin
                        w_en           = 1'b1;
                        w_we           = w_lanes.b.we;
                        w_addr         = w_lanes.b.addr;
                        w_wdata        = w_lanes.b.wdata;
                        w_issue_b_load = is_load(w_lanes.b);
                    end
                end
            end
            ARB_ISSUE_B: begin
                w_en           = 1'b1;
                w_we           = r_b_we;
                w_addr         = r_b_addr;
                w_wdata        = r_b_wdata;
                w_issue_b_load = !r_b_we;
                w_next         = ARB_IDLE;
            end
            default: w_next = ARB_IDLE;
        endcase
        // Port is silent for as long as reset is held, even mid-serialisation.
        if (rst) begin
            w_en           = 1'b0;
            w_we           = 1'b0;
            w_addr         = '0;
            w_wdata        = '0;
            w_stall        = 1'b0;
            w_issue_a_load = 1'b0;
            w_issue_b_load = 1'b0;
            w_latch_b      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_b_we    <= 1'b0;
            r_b_addr  <= '0;
            r_b_wdata <= '0;
            r_tag_a   <= 1'b0;
            r_tag_b   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch_b) begin
                r_b_we    <= w_lanes.b.we;
                r_b_addr  <= w_lanes.b.addr;
                r_b_wdata <= w_lanes.b.wdata;
            end
            r_tag_a <= w_issue_a_load;
            r_tag_b <= w_issue_b_load;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.mem_en    = w_en;
    assign bus.mem_we    = w_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.a_rvalid  = r_tag_a;
    assign bus.b_rvalid  = r_tag_b;
    assign bus.a_rdata   = bus.mem_rdata;
    assign bus.b_rdata   = bus.mem_rdata;

    sat_counter #(
        .W (CNT_W)
    ) u_conflict_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_latch_b),
        .o_count (conflict_cnt)
    );
endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Directed self-checking bench for dmem_port_arbiter (CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] cnt;
    int         n_assert;
    int         n_fail;

    dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .CNT_W  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pair_valid = 1'b0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    endtask

    task automatic set_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.pair_valid = 1'b1;
        bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    endtask

    task automatic set_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.pair_valid = 1'b1;
        bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.mem_rdata = '0;
        idle();
        // Requests present during reset must not reach the port.
        set_a(1'b0, 32'h10, 32'h0);
        set_b(1'b0, 32'h14, 32'h0);
        #2;
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_a_rvalid", bus.a_rvalid, 1'b0);
        chk("rst_b_rvalid", bus.b_rvalid, 1'b0);
        chk("rst_cnt", cnt, 2'd0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        tick();

        // 1. A-only load
        set_a(1'b0, 32'h10, 32'h0);
        #1;
        chk("t1_en", bus.mem_en, 1'b1);
        chk("t1_we", bus.mem_we, 1'b0);
        chk("t1_addr", bus.mem_addr, 32'h10);
        chk("t1_stall", bus.stall, 1'b0);
        tick();
        idle();
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_a_rvalid", bus.a_rvalid, 1'b1);
        chk("t1_a_rdata", bus.a_rdata, 32'hDEADBEEF);
        chk("t1_b_rvalid", bus.b_rvalid, 1'b0);
        chk("t1_idle_en", bus.mem_en, 1'b0);
        tick();
        chk("t1_a_rvalid_clr", bus.a_rvalid, 1'b0);

        // 2. A store + B load conflict
        set_a(1'b1, 32'h20, 32'h11);
        set_b(1'b0, 32'h24, 32'h0);
        #1;
        chk("t2_en_T", bus.mem_en, 1'b1);
        chk("t2_we_T", bus.mem_we, 1'b1);
        chk("t2_addr_T", bus.mem_addr, 32'h20);
        chk("t2_wdata_T", bus.mem_wdata, 32'h11);
        chk("t2_stall_T", bus.stall, 1'b1);
        tick();
        chk("t2_en_T1", bus.mem_en, 1'b1);
        chk("t2_we_T1", bus.mem_we, 1'b0);
        chk("t2_addr_T1", bus.mem_addr, 32'h24);
        chk("t2_stall_T1", bus.stall, 1'b0);
        chk("t2_a_rvalid_T1", bus.a_rvalid, 1'b0);
        chk("t2_cnt", cnt, 2'd1);
        tick();
        idle();
        bus.mem_rdata = 32'hCAFE0024;
        #1;
        chk("t2_b_rvalid_T2", bus.b_rvalid, 1'b1);
        chk("t2_b_rdata_T2", bus.b_rdata, 32'hCAFE0024);
        chk("t2_a_rvalid_T2", bus.a_rvalid, 1'b0);
        chk("t2_en_T2", bus.mem_en, 1'b0);
        tick();

        // 3. B-only load
        set_b(1'b0, 32'h40, 32'h0);
        #1;
        chk("t3_addr", bus.mem_addr, 32'h40);
        chk("t3_en", bus.mem_en, 1'b1);
        chk("t3_stall", bus.stall, 1'b0);
        tick();
        idle();
        #1;
        chk("t3_b_rvalid", bus.b_rvalid, 1'b1);
        chk("t3_a_rvalid", bus.a_rvalid, 1'b0);
        chk("t3_cnt", cnt, 2'd1);
        tick();

        // 4. Requests without pair_valid are ignored
        set_a(1'b0, 32'h50, 32'h0);
        set_b(1'b0, 32'h54, 32'h0);
        bus.pair_valid = 1'b0;
        #1;
        chk("t4_en", bus.mem_en, 1'b0);
        chk("t4_stall", bus.stall, 1'b0);
        tick();
        idle();
        #1;
        chk("t4_a_rvalid", bus.a_rvalid, 1'b0);
        chk("t4_b_rvalid", bus.b_rvalid, 1'b0);
        chk("t4_cnt", cnt, 2'd1);
        tick();

        // 5. Reset pulsed during ARB_ISSUE_B
        set_a(1'b0, 32'h50, 32'h0);
        set_b(1'b0, 32'h54, 32'h0);
        #1;
        chk("t5_stall", bus.stall, 1'b1);
        tick();
        chk("t5_issue_b_addr", bus.mem_addr, 32'h54);
        chk("t5_cnt_pre", cnt, 2'd2);
        rst = 1'b1;
        #1;
        chk("t5_rst_en", bus.mem_en, 1'b0);
        chk("t5_rst_a_rvalid", bus.a_rvalid, 1'b0);
        chk("t5_rst_cnt", cnt, 2'd0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("t5_b_rvalid_0", bus.b_rvalid, 1'b0);
        chk("t5_en_0", bus.mem_en, 1'b0);
        tick();
        chk("t5_b_rvalid_1", bus.b_rvalid, 1'b0);
        set_a(1'b1, 32'h60, 32'h77);
        #1;
        chk("t5_idle_addr", bus.mem_addr, 32'h60);
        chk("t5_idle_stall", bus.stall, 1'b0);
        chk("t5_idle_we", bus.mem_we, 1'b1);
        tick();
        idle();
        #1;
        chk("t5_store_no_rvalid", bus.a_rvalid, 1'b0);
        tick();

        // 6. Five back-to-back conflicts; counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            idle();
            set_a(1'b1, 32'h100 + 32'(k * 8), 32'hA0 + 32'(k));
            set_b(1'b0, 32'h104 + 32'(k * 8), 32'h0);
            #1;
            chk("t6_en_a", bus.mem_en, 1'b1);
            chk("t6_stall_a", bus.stall, 1'b1);
            chk("t6_addr_a", bus.mem_addr, 32'h100 + 32'(k * 8));
            tick();
            chk("t6_en_b", bus.mem_en, 1'b1);
            chk("t6_stall_b", bus.stall, 1'b0);
            chk("t6_addr_b", bus.mem_addr, 32'h104 + 32'(k * 8));
            chk("t6_cnt", cnt, (k < 3) ? 2'(k + 1) : 2'd3);
            tick();
        end
        idle();
        #1;
        chk("t6_cnt_final", cnt, 2'd3);
        chk("t6_last_b_rvalid", bus.b_rvalid, 1'b1);
        chk("t6_last_a_rvalid", bus.a_rvalid, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
